// File: rtl/t05_bit_packer.sv
// Serial-to-word packer: collects code bits MSB-first into WORD_W-bit words,
// buffers them in a small show-ahead FIFO and zero-pads the final partial word on flush.
module t05_bit_packer #(
    parameter int WORD_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    input  logic                    flush,
    output logic [WORD_W-1:0]       word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [$clog2(WORD_W):0] last_bits,
    output logic [31:0]             total_bits,
    output logic                    done,
    output logic [2:0]              dbg_state
);
    localparam int CNTW = $clog2(WORD_W);
    localparam int LBW  = CNTW + 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PACK  = 3'd1,
        S_FLUSH = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNTW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [31:0]       total_q, total_d;
    logic [LBW-1:0]    last_q, last_d;

    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic              push, pop, fifo_full, bit_acc;
    logic [WORD_W-1:0] push_data;
    logic [LBW-1:0]    pad_shift;

    // Handshakes: a bit moves when bit_valid && bit_ready; a word moves when
    // word_valid && word_ready. bit_ready looks only at the registered FIFO count.
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign word_valid = (count_q != '0);
    assign word_out   = mem_q[rd_ptr_q];
    assign pop        = word_valid && word_ready;
    assign bit_acc    = bit_valid && bit_ready;
    assign pad_shift  = LBW'(WORD_W) - {1'b0, bit_cnt_q};

    assign last_bits  = last_q;
    assign total_bits = total_q;
    assign done       = (state_q == S_DONE);
    assign dbg_state  = state_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        total_d   = total_q;
        last_d    = last_q;
        push      = 1'b0;
        push_data = '0;
        bit_ready = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_PACK;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    total_d   = '0;
                    last_d    = '0;
                end
            end
            S_PACK: begin
                bit_ready = !fifo_full;
                if (bit_acc) begin
                    shift_d = {shift_q[WORD_W-2:0], bit_in};
                    total_d = total_q + 32'd1;
                    if (bit_cnt_q == CNTW'(WORD_W - 1)) begin
                        push      = 1'b1;
                        push_data = {shift_q[WORD_W-2:0], bit_in};
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNTW'(1);
                    end
                end
                if (flush) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (bit_cnt_q != '0) begin
                    // Partial bits sit right-aligned in shift_q; left-align them.
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_data = shift_q << pad_shift;
                        last_d    = {1'b0, bit_cnt_q};
                        state_d   = S_DRAIN;
                    end
                end else begin
                    last_d  = (total_q != 32'd0) ? LBW'(WORD_W) : '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (count_q == '0) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            total_q   <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            total_q   <= total_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_t05_bit_packer.sv
// Randomized bench for t05_bit_packer: a queue-based stream model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_t05_bit_packer;
  localparam int W = 32;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_PACK = 1, M_FLUSH = 2, M_DRAIN = 3, M_DONE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, flush = 1'b0, word_ready = 1'b0;
  logic bit_ready, word_valid, done;
  logic [W-1:0] word_out;
  logic [5:0] last_bits;
  logic [31:0] total_bits;
  logic [2:0] dbg_state;
  int rdy_mode = 0;

  always #5 clk = ~clk;

  t05_bit_packer #(.WORD_W(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .flush(flush), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .last_bits(last_bits), .total_bits(total_bits),
    .done(done), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: pending bits, expected word queue, counters
  int m_state = M_IDLE;
  logic [W-1:0] exp_q[$];
  bit pend_q[$];
  logic [31:0] m_total = '0;
  int m_last = 0;
  logic [W-1:0] got_q[$];

  function automatic logic m_bit_ready();
    return (m_state == M_PACK) && (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] v;
    v = '0;
    foreach (pend_q[i]) v[W-1-i] = pend_q[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin : model_blk
    int sz;
    logic acc, pop, have_push;
    logic [W-1:0] w;
    if (rst) begin
      m_state = M_IDLE;
      exp_q.delete();
      pend_q.delete();
      m_total = '0;
      m_last = 0;
    end else begin
      sz = exp_q.size();
      acc = bit_valid && m_bit_ready();
      pop = (sz > 0) && word_ready;
      have_push = 1'b0;
      w = '0;
      case (m_state)
        M_IDLE, M_DONE: if (start) begin
          m_state = M_PACK; m_total = '0; m_last = 0; pend_q.delete();
        end
        M_PACK: begin
          if (acc) begin
            pend_q.push_back(bit_in);
            m_total = m_total + 32'd1;
            if (pend_q.size() == W) begin
              w = pack_bits(); have_push = 1'b1; pend_q.delete();
            end
          end
          if (flush) m_state = M_FLUSH;
        end
        M_FLUSH: begin
          if (pend_q.size() > 0) begin
            if (sz < DEPTH) begin
              w = pack_bits(); have_push = 1'b1;
              m_last = pend_q.size(); pend_q.delete(); m_state = M_DRAIN;
            end
          end else begin
            m_last = (m_total != 0) ? W : 0;
            m_state = M_DRAIN;
          end
        end
        M_DRAIN: if (sz == 0) m_state = M_DONE;
        default: m_state = M_IDLE;
      endcase
      if (pop) void'(exp_q.pop_front());
      if (have_push) exp_q.push_back(w);
    end
  end

  // scoreboard: compare every cycle on the falling edge, log consumed words
  always @(negedge clk) begin
    chk("bit_ready", {63'd0, bit_ready}, {63'd0, m_bit_ready()});
    chk("word_valid", {63'd0, word_valid}, {63'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("word_out", {32'd0, word_out}, {32'd0, exp_q[0]});
    chk("total_bits", {32'd0, total_bits}, {32'd0, m_total});
    chk("last_bits", {58'd0, last_bits}, 64'(m_last));
    chk("done", {63'd0, done}, {63'd0, m_state == M_DONE});
    if (word_valid && word_ready && !rst) got_q.push_back(word_out);
  end

  // word_ready driver: 0 = hold low, 1 = hold high, 2 = random
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: word_ready = 1'b0;
      1: word_ready = 1'b1;
      default: word_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int guard;
    logic acc;
    guard = 0;
    bit_valid = 1'b1; bit_in = b;
    do begin
      acc = bit_ready; tick(); guard++;
    end while (!acc && guard < 2000);
    bit_valid = 1'b0;
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send_bit_timeout: got bit_ready=0 expected 1 within 2000 cycles");
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin tick(); n++; end
    n_checks++;
    if (!done) begin
      n_errors++;
      $display("FAIL wait_done_timeout: got done=0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic check_got(input string name, input int idx, input logic [W-1:0] exp);
    if (idx < got_q.size()) chk(name, {32'd0, got_q[idx]}, {32'd0, exp});
    else begin
      n_checks++; n_errors++;
      $display("FAIL %s: got no word %0d expected %0h", name, idx, exp);
    end
  endtask

  logic [W-1:0] words [5];
  bit sent_q[$];

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_word_valid", {63'd0, word_valid}, 64'd0);
    chk("rst_word_out", {32'd0, word_out}, 64'd0);
    chk("rst_bit_ready", {63'd0, bit_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_total", {32'd0, total_bits}, 64'd0);
    chk("rst_last", {58'd0, last_bits}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // 1: single word streamed with the writer always ready
    rdy_mode = 1; tick();
    got_q.delete();
    do_start();
    send_word(32'hA5A50F0F);
    tick(); tick();
    chk("t1_total", {32'd0, total_bits}, 64'd32);
    chk("t1_count", 64'(got_q.size()), 64'd1);
    check_got("t1_word", 0, 32'hA5A50F0F);
    do_flush(); wait_done(50);
    chk("t1_last", {58'd0, last_bits}, 64'd32);

    // 2: backpressure fills the FIFO, then drains in order
    rdy_mode = 0; tick();
    got_q.delete();
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    do_start();
    for (int i = 0; i < 4; i++) send_word(words[i]);
    bit_valid = 1'b1; bit_in = words[4][W-1];
    repeat (5) tick();
    chk("t2_bit_ready_low", {63'd0, bit_ready}, 64'd0);
    chk("t2_total_128", {32'd0, total_bits}, 64'd128);
    chk("t2_head", {32'd0, word_out}, {32'd0, words[0]});
    bit_valid = 1'b0;
    rdy_mode = 1;
    send_word(words[4]);
    do_flush(); wait_done(100);
    chk("t2_count", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) check_got("t2_order", i, words[i]);

    // 3: 37 bits then flush pads the tail word
    got_q.delete();
    do_start();
    send_word(32'hFFFFFFFF);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    do_flush(); wait_done(100);
    chk("t3_count", 64'(got_q.size()), 64'd2);
    check_got("t3_w0", 0, 32'hFFFFFFFF);
    check_got("t3_w1", 1, 32'hB0000000);
    chk("t3_last", {58'd0, last_bits}, 64'd5);

    // 4: word-aligned flush, then an empty stream
    got_q.delete();
    do_start();
    send_word($urandom); send_word($urandom);
    do_flush(); wait_done(100);
    chk("t4_count", 64'(got_q.size()), 64'd2);
    chk("t4_last", {58'd0, last_bits}, 64'd32);
    got_q.delete();
    do_start(); do_flush(); wait_done(50);
    chk("t4e_count", 64'(got_q.size()), 64'd0);
    chk("t4e_last", {58'd0, last_bits}, 64'd0);
    chk("t4e_done", {63'd0, done}, 64'd1);

    // 5: the 32nd bit arrives together with flush
    got_q.delete();
    do_start();
    for (int i = 0; i < 31; i++) send_bit(1'(i & 1));
    flush = 1'b1; send_bit(1'b1); flush = 1'b0;
    wait_done(100);
    chk("t5_count", 64'(got_q.size()), 64'd1);
    check_got("t5_word", 0, 32'h55555555);
    chk("t5_last", {58'd0, last_bits}, 64'd32);

    // random streams: random lengths, gaps, writer stalls and ignored starts
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      int n, nw;
      logic [W-1:0] ew;
      got_q.delete(); sent_q.delete();
      n = $urandom_range(0, 100);
      do_start();
      for (int i = 0; i < n; i++) begin
        bit b;
        if ($urandom_range(0, 3) == 0) begin
          start = ($urandom_range(0, 3) == 0);
          repeat ($urandom_range(1, 3)) tick();
          start = 1'b0;
        end
        b = 1'($urandom);
        sent_q.push_back(b);
        send_bit(b);
      end
      do_flush(); wait_done(500);
      nw = (n + W - 1) / W;
      chk("rnd_count", 64'(got_q.size()), 64'(nw));
      chk("rnd_last", {58'd0, last_bits}, 64'((n == 0) ? 0 : ((n % W == 0) ? W : n % W)));
      for (int k = 0; k < nw; k++) begin
        ew = '0;
        for (int j = 0; j < W; j++) if (k * W + j < n) ew[W-1-j] = sent_q[k*W+j];
        check_got("rnd_word", k, ew);
      end
    end

    // 6: reset mid-stream with two queued words and a partial word
    rdy_mode = 0; tick();
    do_start();
    for (int i = 0; i < 74; i++) send_bit(1'($urandom));
    chk("t6_pre_valid", {63'd0, word_valid}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_word_valid", {63'd0, word_valid}, 64'd0);
    chk("t6_done", {63'd0, done}, 64'd0);
    chk("t6_total", {32'd0, total_bits}, 64'd0);
    chk("t6_bit_ready", {63'd0, bit_ready}, 64'd0);
    chk("t6_state_idle", {61'd0, dbg_state}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
